// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//
// Turns 10-bit command words from an SPI slave into single-port RAM accesses.
// Each word carries a 2-bit opcode and an 8-bit payload:
//   00 load write pointer, 01 write payload at write pointer,
//   10 load read pointer,  11 read at read pointer and return the byte.
// Commands that arrive while a RAM transaction is still in flight are not
// executed; they are counted in a saturating drop counter instead.
//
// Parameters
//   ADDR_W   RAM address width
//   RD_LAT   RAM read latency in clocks (1..4), from ram_re to ram_dout valid
//   AUTO_INC 1: pointers advance after each data access, 0: pointers hold
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   rx_data, rx_valid command word from the SPI slave and its one-cycle strobe
//   tx_data, tx_valid read-back byte to the SPI slave and its one-cycle strobe
//   ram_addr, ram_din RAM address and write data
//   ram_we, ram_re    RAM write / read strobes (never both high)
//   ram_dout          RAM read data
//   busy              controller is not idle
//   drop_cnt          number of commands dropped while busy (saturates at 255)
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  // READ_WAIT lasts RD_LAT cycles; ram_dout is valid in its last cycle.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);

  state_t            state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [1:0]        lat_cnt_r;
  logic [1:0]        opcode_s;
  logic [7:0]        payload_s;

  assign opcode_s  = rx_data[9:8];
  assign payload_s = rx_data[7:0];

  // busy is the only output decoded straight from the state register.
  assign busy = (state_r != IDLE);

  // Zero-extend or truncate the 8-bit payload to a pointer.
  function automatic logic [ADDR_W-1:0] to_ptr(input logic [7:0] p);
    return ADDR_W'(p);
  endfunction

  // Post-access pointer value; natural modulo-2^ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] p);
    if (AUTO_INC != 0) begin
      return p + PTR_ONE;
    end else begin
      return p;
    end
  endfunction

  // Command FSM, pointers, registered RAM/SPI outputs and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      lat_cnt_r <= 2'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= 8'd0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      // A command seen outside IDLE is never executed, only counted.
      if (rx_valid && (state_r != IDLE) && (drop_cnt != 8'd255)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state_r)
        IDLE: begin
          tx_valid <= 1'b0;
          ram_we   <= 1'b0;
          ram_re   <= 1'b0;
          ram_addr <= wr_ptr_r;
          if (rx_valid) begin
            case (opcode_s)
              2'b00: begin
                // Pointer loads complete in IDLE; ram_addr tracks the new wr_ptr.
                wr_ptr_r <= to_ptr(payload_s);
                ram_addr <= to_ptr(payload_s);
              end
              2'b01: begin
                ram_we   <= 1'b1;
                ram_din  <= payload_s;
                state_r  <= WRITE;
              end
              2'b10: begin
                rd_ptr_r <= to_ptr(payload_s);
              end
              2'b11: begin
                ram_re   <= 1'b1;
                ram_addr <= rd_ptr_r;
                state_r  <= READ_REQ;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end
        end

        WRITE: begin
          ram_we   <= 1'b0;
          wr_ptr_r <= bump(wr_ptr_r);
          ram_addr <= bump(wr_ptr_r);
          state_r  <= IDLE;
        end

        READ_REQ: begin
          ram_re    <= 1'b0;
          rd_ptr_r  <= bump(rd_ptr_r);
          ram_addr  <= bump(rd_ptr_r);
          lat_cnt_r <= 2'd0;
          state_r   <= READ_WAIT;
        end

        READ_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            tx_data  <= ram_dout;
            tx_valid <= 1'b1;
            ram_addr <= wr_ptr_r;
            state_r  <= RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end

        RESP: begin
          tx_valid <= 1'b0;
          ram_addr <= wr_ptr_r;
          state_r  <= IDLE;
        end

        default: begin
          tx_valid <= 1'b0;
          ram_we   <= 1'b0;
          ram_re   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for spi_ram_ctrl (ADDR_W=8, RD_LAT=3, AUTO_INC=1).
// Accepted commands push expected RAM strobes and read-back bytes (with the
// cycle they must appear in) onto queues; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  a;
    logic [7:0]  d;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        ram_dout;
  logic              busy;
  logic [7:0]        drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_tx     = 0;
  logic [31:0] cyc = 32'd0;

  ev_t q_wr[$];
  ev_t q_rd[$];
  ev_t q_tx[$];
  ev_t e;

  logic [7:0] ram_mem [256];
  logic [7:0] m_mem   [256];
  logic [7:0] pipe    [RD_LAT];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] exp_drop;

  spi_ram_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .AUTO_INC(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_dout (ram_dout),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // RAM device: synchronous write, RD_LAT-stage read pipeline.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    pipe[0] <= ram_re ? ram_mem[ram_addr] : 8'hEE;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_dout = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every strobe the DUT produces against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we || ram_re) chk("strobe_excl", 32'(ram_we & ram_re), 32'd0);
      if (ram_we) begin
        if (q_wr.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
        else begin
          e = q_wr.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_addr", 32'(ram_addr), 32'(e.a));
          chk("we_din", 32'(ram_din), 32'(e.d));
        end
      end
      if (ram_re) begin
        if (q_rd.size() == 0) chk("re_unexpected", 32'd1, 32'd0);
        else begin
          e = q_rd.pop_front();
          chk("re_cycle", cyc, e.cyc);
          chk("re_addr", 32'(ram_addr), 32'(e.a));
        end
      end
      if (tx_valid) begin
        n_tx++;
        if (q_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else begin
          e = q_tx.pop_front();
          chk("tx_cycle", cyc, e.cyc);
          chk("tx_data", 32'(tx_data), 32'(e.d));
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge; issues one command that the DUT accepts at the next edge.
  task automatic send(input logic [9:0] cmd);
    logic [31:0] c;
    wait_idle();
    c = cyc;
    rx_data  = cmd;
    rx_valid = 1'b1;
    case (cmd[9:8])
      2'b00: m_wr = cmd[7:0];
      2'b01: begin
        q_wr.push_back(ev_t'{c + 32'd1, m_wr, cmd[7:0]});
        m_mem[m_wr] = cmd[7:0];
        m_wr = m_wr + 8'd1;
      end
      2'b10: m_rd = cmd[7:0];
      default: begin
        q_rd.push_back(ev_t'{c + 32'd1, m_rd, 8'd0});
        q_tx.push_back(ev_t'{c + 32'(RD_LAT) + 32'd2, 8'd0, m_mem[m_rd]});
        m_rd = m_rd + 8'd1;
        n_reads++;
      end
    endcase
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 10'd0;
    m_wr     = 8'd0;
    m_rd     = 8'd0;
    exp_drop = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i) ^ 8'h5A;
      m_mem[i]   = 8'(i) ^ 8'h5A;
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din",  32'(ram_din),  32'd0);
    chk("rst_ram_we",   32'(ram_we),   32'd0);
    chk("rst_ram_re",   32'(ram_re),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Write then read back; first command right after release.
    rst = 1'b0;
    send(10'h005);
    send(10'h1AB);
    send(10'h205);
    send(10'h300);

    // Write pointer wrap 0xFF -> 0x00 -> 0x01.
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    wait_idle();
    chk("wrap_wr_ptr", 32'(ram_addr), 32'h01);

    // Command while busy is dropped and counted.
    send(10'h300);
    rx_data  = 10'h1CC;
    rx_valid = 1'b1;
    exp_drop = exp_drop + 8'd1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle();
    chk("drop_one", 32'(drop_cnt), 32'(exp_drop));

    // Drive well over 255 drops; counter must saturate.
    for (int r = 0; r < 62; r++) begin
      send(10'h300);
      for (int g = 0; g < 20 && busy === 1'b1; g++) begin
        rx_data  = 10'h1CC;
        rx_valid = 1'b1;
        if (exp_drop != 8'd255) exp_drop = exp_drop + 8'd1;
        @(negedge clk);
      end
      rx_valid = 1'b0;
    end
    wait_idle();
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
    chk("drop_model", 32'(exp_drop), 32'd255);

    // Random command stream.
    for (int i = 0; i < 40; i++) begin
      send({2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))});
    end

    // Reset during READ_WAIT aborts the read.
    wait_idle();
    send(10'h2A0);
    send(10'h300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_tx_data",  32'(tx_data),  32'd0);
    chk("abort_ram_re",   32'(ram_re),   32'd0);
    chk("abort_ram_we",   32'(ram_we),   32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_ram_din",  32'(ram_din),  32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_drop_cnt", 32'(drop_cnt), 32'd0);
    n_reads = n_reads - q_tx.size();
    q_tx.delete();
    m_wr = 8'd0;
    m_rd = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(10'h300);

    // Drain and final bookkeeping.
    wait_idle();
    repeat (10) @(negedge clk);
    chk("q_wr_empty", 32'(q_wr.size()), 32'd0);
    chk("q_rd_empty", 32'(q_rd.size()), 32'd0);
    chk("q_tx_empty", 32'(q_tx.size()), 32'd0);
    chk("tx_count", 32'(n_tx), 32'(n_reads));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: RAM address width in bits.
REQ-002 Parameter RD_LAT, default 1, legal range 1..4: RAM read latency in clocks, from ram_re high to ram_dout valid.
REQ-003 Parameter AUTO_INC, default 1: when 1, the address pointer increments after each data access; when 0, it holds.
REQ-004 Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rx_data, input, 10: command word from the SPI slave; [9:8] is the opcode, [7:0] is the payload.
- rx_valid, input, 1: rx_data valid for one cycle.
- tx_data, output, 8: read-back byte to the SPI slave.
- tx_valid, output, 1: tx_data valid for one cycle.
- ram_addr, output, ADDR_W: RAM address.
- ram_din, output, 8: RAM write data.
- ram_we, output, 1: RAM write strobe.
- ram_re, output, 1: RAM read strobe.
- ram_dout, input, 8: RAM read data.
- busy, output, 1: controller not in IDLE.
- drop_cnt, output, 8: count of dropped commands.

Function
REQ-005 Opcodes: 00 = load wr_ptr from payload; 01 = write payload at wr_ptr; 10 = load rd_ptr from payload; 11 = read at rd_ptr (payload ignored).
REQ-006 Payload is zero-extended or truncated to ADDR_W when loaded into a pointer.
REQ-007 FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
REQ-008 A command is accepted only when rx_valid=1 and state=IDLE at the same clock edge.
REQ-009 rx_valid=1 while state!=IDLE shall not be executed; drop_cnt increments by 1 and saturates at 255.
REQ-010 Opcode 00 or 10 accepted at edge N: the pointer updates at N+1; the state stays IDLE; no RAM strobe is issued.
REQ-011 Opcode 01 accepted at edge N, WRITE state:
- ram_we=1 for exactly the cycle after edge N.
- ram_addr=wr_ptr and ram_din=payload during that cycle.
- Return to IDLE at N+2.
REQ-012 Opcode 11 accepted at edge N:
- READ_REQ: ram_re=1 for one cycle with ram_addr=rd_ptr.
- READ_WAIT: a latency counter runs RD_LAT-1 further cycles.
- ram_dout is captured into tx_data RD_LAT cycles after the ram_re cycle.
- RESP: tx_valid=1 for exactly one cycle.
- Return to IDLE on the next edge.
- Total latency: tx_valid high in cycle N+RD_LAT+2.
REQ-013 tx_data shall hold its last value until the next capture.
REQ-014 When AUTO_INC=1, wr_ptr increments once at the end of WRITE, and rd_ptr increments once at the end of READ_REQ.
REQ-015 Pointer increments wrap from 2^ADDR_W-1 to 0.
REQ-016 ram_we and ram_re shall never be high together; both are low in IDLE and RESP.
REQ-017 ram_addr outputs wr_ptr in IDLE and WRITE, and rd_ptr in READ_REQ and READ_WAIT.
REQ-018 busy=1 in every state except IDLE.
REQ-019 All outputs are registered, except busy, which is decoded from the state register.

Reset
REQ-020 rst=1 forces asynchronously:
- state=IDLE.
- wr_ptr, rd_ptr, tx_data, ram_din and drop_cnt = 0.
- tx_valid, ram_we and ram_re = 0.
REQ-021 Reset asserted mid-read shall abort the transaction; no tx_valid is produced for it after release.
REQ-022 After reset release, the first rx_valid is accepted on the next clock edge.

Verification
REQ-023 Write then read: rx 0x005, 0x1AB, 0x205, 0x300 with RD_LAT=1 -> ram_we with addr 5 and din 0xAB; ram_re with addr 5; tx_valid with tx_data 0xAB three cycles after the read is accepted.
REQ-024 Auto-increment wrap with ADDR_W=8: rx 0x0FF, then 0x111 and 0x122 -> writes at 0xFF then 0x00; wr_ptr=0x01 afterwards.
REQ-025 Busy drop: assert 0x300 and, one cycle later, 0x1CC -> the second command is not executed; drop_cnt=1; drop_cnt saturates at 255 after 300 drops.
REQ-026 RD_LAT=3: read accepted at edge N -> ram_re high only in cycle N+1; tx_valid high only in cycle N+5.
REQ-027 Reset mid-read: pulse rst during READ_WAIT -> all outputs 0 immediately; no tx_valid afterwards; the next 0x300 reads address 0.
REQ-028 Strobe exclusivity: random command stream -> ram_we & ram_re never both 1; tx_valid count equals the number of accepted opcode-11 commands.
